// File: rtl/acc_pkg.sv
// acc_pkg: shared FSM state type, default widths and slice-count derivation for the IFM fetch path
package acc_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;
  localparam int DEF_INPUT_WIDTH  = 512;
  localparam int DEF_OUTPUT_WIDTH = 80;
  localparam int DEF_REG_NUM      = 5;
  localparam int DEF_CHUNK_W      = 16;
  function automatic int calc_max_cnt(input int input_width, input int output_width, input int reg_num);
    return input_width * reg_num / output_width;
  endfunction
endpackage

// File: rtl/edge_detect.sv
// edge_detect: registered rising-edge detector (one cycle high when sig goes 0->1)
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);
  logic sig_q;
  // remember last sampled level so a held level yields only one edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig_q <= 1'b0;
    else sig_q <= sig;
  assign rise = sig && !sig_q;
endmodule

// File: rtl/ifm_fetch_sched.sv
// ifm_fetch_sched: conv sequencer gating AXIS IFM words into the parser and slices out to the PE array; IFM_FETCH_SCHED_PERF_EN adds a stall_cycles counter
module ifm_fetch_sched
  import acc_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int REG_NUM      = DEF_REG_NUM,
  parameter int MAX_CNT      = calc_max_cnt(INPUT_WIDTH, OUTPUT_WIDTH, REG_NUM),
  parameter int CHUNK_W      = DEF_CHUNK_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CHUNK_W-1:0]     cfg_num_chunks,
  input  logic                   s_axis_tvalid,
  input  logic [INPUT_WIDTH-1:0] s_axis_tdata,
  output logic                   s_axis_tready,
  output logic [INPUT_WIDTH-1:0] fm,
  input  logic                   input_req,
  output logic                   start_conv_pulse,
  output logic                   ifm_read,
  input  logic                   pe_ready,
  output logic                   slice_valid,
  output logic                   end_conv,
`ifdef IFM_FETCH_SCHED_PERF_EN
  output logic [31:0]            stall_cycles,
`endif
  output logic                   busy
);
  localparam int SW = $clog2(MAX_CNT);
  localparam int RW = $clog2(REG_NUM + 1);
  localparam logic [SW-1:0] S_LAST       = SW'(MAX_CNT - 1);
  localparam logic [RW-1:0] R_FULL       = RW'(REG_NUM);
  localparam logic [RW-1:0] R_PRIME_LAST = RW'(REG_NUM - 1);

  state_t             state, state_d;
  logic [CHUNK_W-1:0] num_q, chunk_cnt;
  logic [SW-1:0]      slice_cnt;
  logic [RW-1:0]      refill_cnt;
  logic               rise, go, last_chunk, accept, boundary;

  edge_detect u_edge (.clk(clk), .rst_n(rst_n), .sig(start), .rise(rise));

  assign fm          = s_axis_tdata;
  assign slice_valid = ifm_read;
  assign busy        = state != IDLE;
  assign end_conv    = state == DONE;

  // handshake gating and next state; the chunk-end slice waits for a full refill so the parser never underruns
  always_comb begin
    go            = state == IDLE && rise && cfg_num_chunks != '0;
    last_chunk    = state == RUN && chunk_cnt == num_q - CHUNK_W'(1);
    s_axis_tready = input_req && (state == PRIME || state == RUN) && refill_cnt < R_FULL && !last_chunk;
    accept        = s_axis_tvalid && s_axis_tready;
    ifm_read      = state == RUN && pe_ready && !(slice_cnt == S_LAST && !last_chunk && refill_cnt != R_FULL);
    boundary      = ifm_read && slice_cnt == S_LAST;
    state_d       = abort ? IDLE :
                    state == IDLE  ? (go ? PRIME : IDLE) :
                    state == PRIME ? (accept && refill_cnt == R_PRIME_LAST ? RUN : PRIME) :
                    state == RUN   ? (boundary && last_chunk ? DONE : RUN) : IDLE;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;

  // chunk/slice/refill bookkeeping; in RUN refill_cnt tracks words buffered for the next chunk
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || abort) begin
      start_conv_pulse <= 1'b0;
      num_q            <= '0;
      chunk_cnt        <= '0;
      slice_cnt        <= '0;
      refill_cnt       <= '0;
    end else begin
      start_conv_pulse <= go;
      if (go) begin
        num_q      <= cfg_num_chunks;
        chunk_cnt  <= '0;
        slice_cnt  <= '0;
        refill_cnt <= '0;
      end else if (state == PRIME) begin
        refill_cnt <= accept && refill_cnt == R_PRIME_LAST ? '0 : refill_cnt + RW'(accept);
      end else if (state == RUN) begin
        if (ifm_read) slice_cnt <= boundary ? '0 : slice_cnt + SW'(1);
        if (boundary) chunk_cnt <= chunk_cnt + CHUNK_W'(1);
        refill_cnt <= boundary ? RW'(accept) : refill_cnt + RW'(accept);
      end
    end

`ifdef IFM_FETCH_SCHED_PERF_EN
  // saturating count of RUN cycles where the PE could take a slice but none was offered
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cycles <= '0;
    else if (abort || go) stall_cycles <= '0;
    else if (state == RUN && pe_ready && !ifm_read && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_ifm_fetch_sched.sv
// tb_ifm_fetch_sched: directed self-checking bench for ifm_fetch_sched
module tb_ifm_fetch_sched;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic s_axis_tvalid = 1'b0, input_req = 1'b1, pe_ready = 1'b1;
  logic [15:0] cfg_num_chunks = '0;
  logic [511:0] s_axis_tdata = '0;
  logic s_axis_tready, start_conv_pulse, ifm_read, slice_valid, end_conv, busy;
  logic [511:0] fm;
  logic [63:0] tdata_exp;
`ifdef IFM_FETCH_SCHED_PERF_EN
  logic [31:0] stall_cycles;
`endif
  int total = 0, bad = 0;
  int cyc = 0, reads = 0, accepts = 0, pulses = 0, ends = 0, sv_bad = 0;
  int first_acc = 0, first_read_cyc = 0, prime_done_cyc = 0, last_read_cyc = 0, end_cyc = 0;
  int rd_base = 0, acc_base = 0, pl_base = 0, en_base = 0, sv_base = 0, snap = 0;

  always #5 clk = ~clk;

  ifm_fetch_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_num_chunks(cfg_num_chunks),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
    .fm(fm), .input_req(input_req), .start_conv_pulse(start_conv_pulse), .ifm_read(ifm_read),
    .pe_ready(pe_ready), .slice_valid(slice_valid), .end_conv(end_conv),
`ifdef IFM_FETCH_SCHED_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .busy(busy)
  );

  always @(posedge clk) begin
    cyc++;
    if (ifm_read !== slice_valid) sv_bad++;
    if (ifm_read) begin
      if (reads == rd_base) begin
        first_read_cyc = cyc;
        first_acc = accepts - acc_base;
      end
      reads++;
      last_read_cyc = cyc;
    end
    if (s_axis_tvalid && s_axis_tready) begin
      if (accepts - acc_base == 4) prime_done_cyc = cyc;
      accepts++;
    end
    if (end_conv) begin
      ends++;
      end_cyc = cyc;
    end
    if (start_conv_pulse) pulses++;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic begin_conv(input int n);
    start = 1'b0;
    cfg_num_chunks = 16'(n);
    @(negedge clk);
    start = 1'b1;
    rd_base = reads; acc_base = accepts; pl_base = pulses; en_base = ends; sv_base = sv_bad;
    @(negedge clk);
  endtask

  task automatic wait_end(input int lim);
    for (int i = 0; i < lim && !end_conv; i++) @(negedge clk);
    if (!end_conv) chk("end_timeout", 0, 1);
  endtask

  task automatic wait_reads(input int n);
    for (int i = 0; i < 500 && reads - rd_base != n; i++) @(negedge clk);
    if (reads - rd_base != n) chk("read_timeout", reads - rd_base, n);
  endtask

  task automatic run_hold(input int hold);
    s_axis_tvalid = 1'b0;
    pe_ready = 1'b1;
    begin_conv(2);
    s_axis_tvalid = 1'b1;
    repeat (5) @(negedge clk);
    s_axis_tvalid = 1'b0;
    wait_reads(31);
    chk("hold_at_31", ifm_read, 0);
    repeat (hold) @(negedge clk);
    chk("still_held", ifm_read, 0);
    s_axis_tvalid = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_read_during_refill", reads - rd_base, 31);
    chk("release_read", ifm_read, 1);
    @(negedge clk);
    chk("slice31_once", reads - rd_base, 32);
    wait_end(300);
    chk("hold_reads64", reads - rd_base, 64);
    chk("hold_acc10", accepts - acc_base, 10);
  endtask

  initial begin
    s_axis_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_pulse", start_conv_pulse, 0);
    chk("rst_read", ifm_read, 0);
    chk("rst_valid", slice_valid, 0);
    chk("rst_end", end_conv, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    tdata_exp = {$urandom(), $urandom()};
    s_axis_tdata = {448'd0, tdata_exp};
    #1 chk("fm_pass", fm[63:0], tdata_exp);

    // basic two-chunk conv
    begin_conv(2);
    chk("pulse_c1", start_conv_pulse, 1);
    chk("busy_run", busy, 1);
    wait_end(300);
    chk("reads64", reads - rd_base, 64);
    chk("acc10", accepts - acc_base, 10);
    chk("prime_acc5", first_acc, 5);
    chk("first_read_lat", first_read_cyc - prime_done_cyc, 1);
    @(negedge clk);
    chk("end_lat", end_cyc - last_read_cyc, 1);
    chk("end_one_cycle", end_conv, 0);
    chk("busy_fall", busy, 0);
    chk("pulses1", pulses - pl_base, 1);
    chk("ends1", ends - en_base, 1);

    // refill withheld at the chunk boundary
    run_hold(2);
`ifdef IFM_FETCH_SCHED_PERF_EN
    chk("stall7", stall_cycles, 7);
`endif
    @(negedge clk);

    // random pe back-pressure over three chunks
    s_axis_tvalid = 1'b1;
    begin_conv(3);
    for (int i = 0; i < 3000 && !end_conv; i++) begin
      pe_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (!end_conv) chk("rand_timeout", 0, 1);
    chk("rand_reads96", reads - rd_base, 96);
    chk("rand_acc15", accepts - acc_base, 15);
    chk("valid_eq_read", sv_bad - sv_base, 0);
    pe_ready = 1'b1;
    @(negedge clk);
    chk("rand_busy_fall", busy, 0);

    // zero-chunk start is ignored
    begin_conv(0);
    chk("zero_busy", busy, 0);
    chk("zero_pulse", start_conv_pulse, 0);
    chk("zero_tready", s_axis_tready, 0);

    // abort beats a simultaneous start edge
    start = 1'b0;
    cfg_num_chunks = 16'd2;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    pl_base = pulses;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_pulse", pulses - pl_base, 0);

    // abort mid-RUN at slice 10, then a clean conv
    begin_conv(2);
    wait_reads(10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_tready", s_axis_tready, 0);
    chk("abort_read", ifm_read, 0);
    snap = reads;
    repeat (40) @(negedge clk);
    chk("abort_no_end", ends - en_base, 0);
    chk("abort_no_reads", reads - snap, 0);
    begin_conv(2);
    wait_end(300);
    chk("post_abort_reads", reads - rd_base, 64);
    chk("post_abort_acc", accepts - acc_base, 10);
    @(negedge clk);

    // asynchronous reset mid-conv
    begin_conv(2);
    repeat (3) @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("midrst_busy", busy, 0);
    chk("midrst_tready", s_axis_tready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
